// File: rtl/stream_maxpool.sv
// Streaming 1-D signed max-pool: non-overlapping windows of POOL samples within
// vectors of LENY samples, one registered result per window on a valid/ready output.
module stream_maxpool #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned POOL    = 2,
   parameter int unsigned LOGPOOL = 1,
   parameter int unsigned LENY    = 5,
   parameter int unsigned LOGLENY = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data_in_y,
   input  logic             s_valid_y,
   output logic             s_ready_y,
   output logic [WIDTH-1:0] m_data_out_z,
   output logic             m_valid_z,
   input  logic             m_ready_z
);

   logic [LOGPOOL-1:0] r_cnt;
   logic [LOGLENY-1:0] r_fcnt;
   logic [WIDTH-1:0]   r_max;

   logic               w_accept;
   logic               w_closing;
   logic               w_last_vec;
   logic [WIDTH-1:0]   w_cand;

   assign w_last_vec = (r_fcnt == LOGLENY'(LENY - 1));
   assign w_closing  = (r_cnt == LOGPOOL'(POOL - 1)) | w_last_vec;
   // Only a window-closing sample needs the output slot, so only it can stall.
   assign s_ready_y  = !(w_closing & m_valid_z & !m_ready_z);
   assign w_accept   = s_valid_y & s_ready_y;

   // First sample of a window starts a fresh maximum.
   always_comb begin
      w_cand = s_data_in_y;
      if ((r_cnt != '0) && ($signed(r_max) > $signed(s_data_in_y)))
         w_cand = r_max;
   end

   // Window/vector counters, running max and the EMPTY/FULL output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_fcnt       <= '0;
         r_max        <= '0;
         m_data_out_z <= '0;
         m_valid_z    <= 1'b0;
      end else begin
         if (m_valid_z && m_ready_z)
            m_valid_z <= 1'b0;
         if (w_accept) begin
            if (w_closing) begin
               m_data_out_z <= w_cand;
               m_valid_z    <= 1'b1;
               r_cnt        <= '0;
               r_fcnt       <= w_last_vec ? '0 : r_fcnt + LOGLENY'(1);
            end else begin
               r_max  <= w_cand;
               r_cnt  <= r_cnt + LOGPOOL'(1);
               r_fcnt <= r_fcnt + LOGLENY'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_maxpool.sv
// Self-checking bench for stream_maxpool (WIDTH=8, POOL=2, LENY=5): directed
// scenarios plus a randomized stream scored against a window-max reference model.
module tb_stream_maxpool;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned POOL  = 2;
   localparam int unsigned LENY  = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] s_data_in_y = '0;
   logic             s_valid_y = 1'b0;
   logic             s_ready_y;
   logic [WIDTH-1:0] m_data_out_z;
   logic             m_valid_z;
   logic             m_ready_z = 1'b0;

   int checks   = 0;
   int failures = 0;

   int got_q[$];
   int vhist[$];
   int sready_low;
   int hold_viol;

   stream_maxpool #(.WIDTH(WIDTH), .POOL(POOL), .LOGPOOL(1), .LENY(LENY), .LOGLENY(3)) dut (
      .clk(clk), .reset(reset),
      .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
      .m_data_out_z(m_data_out_z), .m_valid_z(m_valid_z), .m_ready_z(m_ready_z)
   );

   always #5 clk = ~clk;

   // Reference: each vector is cut into POOL-sized windows, last one may be short.
   function automatic void model(input int samp[$], output int exp_q[$]);
      int cur;
      exp_q.delete();
      cur = 0;
      for (int i = 0; i < samp.size(); i++) begin
         int pos;
         pos = i % LENY;
         if (pos % POOL == 0) cur = samp[i];
         else if (samp[i] > cur) cur = samp[i];
         if ((pos % POOL == POOL - 1) || (pos == LENY - 1)) exp_q.push_back(cur);
      end
   endfunction

   task automatic do_reset();
      @(negedge clk);
      s_valid_y = 1'b0;
      m_ready_z = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives samples one per negedge, observes at negedge+1; the following posedge commits.
   task automatic run_stream(input int samp[$], input int rdy_hold, input int rdy_mode,
                             input bit gaps, input bit drain);
      int  idx;
      int  cyc;
      bit  prev_hold;
      bit  all_sent;
      bit  done;
      logic [WIDTH-1:0] prev_data;
      idx = 0; cyc = 0; prev_hold = 1'b0; prev_data = '0; done = 1'b0;
      got_q.delete(); vhist.delete(); sready_low = 0; hold_viol = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         all_sent    = (idx == samp.size());
         s_valid_y   = !all_sent && (!gaps || $urandom_range(0, 3) != 0);
         s_data_in_y = all_sent ? WIDTH'($urandom) : WIDTH'(samp[idx]);
         if (cyc < rdy_hold)   m_ready_z = 1'b0;
         else if (rdy_mode == 0) m_ready_z = 1'b1;
         else if (rdy_mode == 1) m_ready_z = ($urandom_range(0, 9) < 7);
         else                  m_ready_z = 1'b0;
         #1;
         vhist.push_back(int'(m_valid_z));
         if (!s_ready_y) sready_low++;
         if (prev_hold && m_data_out_z !== prev_data) hold_viol++;
         prev_hold = m_valid_z && !m_ready_z;
         prev_data = m_data_out_z;
         if (m_valid_z && m_ready_z) got_q.push_back(int'($signed(m_data_out_z)));
         if (s_valid_y && s_ready_y) idx++;
         cyc++;
         if (all_sent && (!drain || !m_valid_z)) done = 1'b1;
      end
      s_valid_y = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL stream_timeout: got %0d cycles without completion, required completion", cyc);
      end
   endtask

   task automatic compare_outputs(input string name, input int exp_q[$]);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d outputs, required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d, required %0d", name, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (m_valid_z !== 1'b0 || m_data_out_z !== '0 || s_ready_y !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: got valid=%b data=%0h ready=%b, required valid=0 data=0 ready=1",
                  m_valid_z, m_data_out_z, s_ready_y);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_continuous();
      int samp[$];
      int exp_q[$];
      int exp_v[$];
      samp  = '{3, -1, 7, 7, 2};
      exp_q = '{3, 7, 2};
      exp_v = '{0, 0, 1, 0, 1, 1, 0};
      do_reset();
      run_stream(samp, 0, 0, 1'b0, 1'b1);
      compare_outputs("continuous", exp_q);
      checks++;
      if (vhist.size() !== exp_v.size()) begin
         failures++;
         $display("FAIL continuous_len: got %0d cycles, required %0d", vhist.size(), exp_v.size());
      end
      for (int i = 0; i < exp_v.size() && i < vhist.size(); i++) begin
         checks++;
         if (vhist[i] !== exp_v[i]) begin
            failures++;
            $display("FAIL continuous_valid[%0d]: got %0d, required %0d", i, vhist[i], exp_v[i]);
         end
      end
      checks++;
      if (sready_low !== 0) begin
         failures++;
         $display("FAIL continuous_ready: got %0d stall cycles, required 0", sready_low);
      end
   endtask

   task automatic test_negative();
      int samp[$];
      int exp_q[$];
      samp  = '{-5, -3, -128, -127, -1};
      exp_q = '{-3, -127, -1};
      do_reset();
      run_stream(samp, 0, 0, 1'b0, 1'b1);
      compare_outputs("negative", exp_q);
   endtask

   task automatic test_backpressure();
      int samp[$];
      int exp_q[$];
      samp  = '{1, 4, 9, 6, 5};
      exp_q = '{4, 9, 5};
      do_reset();
      run_stream(samp, 6, 0, 1'b0, 1'b1);
      compare_outputs("backpressure", exp_q);
      checks++;
      if (sready_low !== 3) begin
         failures++;
         $display("FAIL backpressure_stall: got %0d stall cycles, required 3", sready_low);
      end
      checks++;
      if (hold_viol !== 0) begin
         failures++;
         $display("FAIL backpressure_hold: got %0d data changes while held, required 0", hold_viol);
      end
   endtask

   task automatic test_drain_load();
      int samp[$];
      int exp_q[$];
      samp  = '{10, 20, 30, 40, 50};
      exp_q = '{20, 40, 50};
      do_reset();
      run_stream(samp, 4, 0, 1'b0, 1'b1);
      compare_outputs("drain_load", exp_q);
      for (int i = 2; i <= 6; i++) begin
         checks++;
         if (i >= vhist.size() || vhist[i] !== 1) begin
            failures++;
            $display("FAIL drain_load_valid[%0d]: got %0d, required 1", i,
                     (i < vhist.size()) ? vhist[i] : -1);
         end
      end
   endtask

   task automatic test_async_reset();
      int samp[$];
      int exp_q[$];
      samp = '{7, 5, 9};
      do_reset();
      run_stream(samp, 1000, 2, 1'b0, 1'b0);
      checks++;
      if (m_valid_z !== 1'b1 || s_ready_y !== 1'b0) begin
         failures++;
         $display("FAIL async_pre: got valid=%b ready=%b, required valid=1 ready=0", m_valid_z, s_ready_y);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (m_valid_z !== 1'b0 || s_ready_y !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: got valid=%b ready=%b, required valid=0 ready=1", m_valid_z, s_ready_y);
      end
      reset = 1'b0;
      samp  = '{2, 1, 0, 0, 0};
      exp_q = '{2, 0, 0};
      run_stream(samp, 0, 0, 1'b0, 1'b1);
      compare_outputs("async_after", exp_q);
   endtask

   task automatic test_frame_boundary();
      int samp[$];
      int exp_q[$];
      samp  = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
      exp_q = '{2, 4, 50, 7, 9, 10};
      do_reset();
      run_stream(samp, 0, 0, 1'b0, 1'b1);
      compare_outputs("frame", exp_q);
   endtask

   task automatic test_random();
      int samp[$];
      int exp_q[$];
      for (int i = 0; i < 40 * LENY; i++) begin
         case ($urandom_range(0, 7))
            0:       samp.push_back(-128);
            1:       samp.push_back(127);
            default: samp.push_back(int'($signed(WIDTH'($urandom))));
         endcase
      end
      model(samp, exp_q);
      do_reset();
      run_stream(samp, 0, 1, 1'b1, 1'b1);
      compare_outputs("random", exp_q);
      checks++;
      if (hold_viol !== 0) begin
         failures++;
         $display("FAIL random_hold: got %0d data changes while held, required 0", hold_viol);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_negative();
      test_backpressure();
      test_drain_load();
      test_async_reset();
      test_frame_boundary();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_maxpool.md
# stream_maxpool

Streaming 1-D max-pool stage that sits directly downstream of the convolution block and consumes its `m_data_out_y` valid/ready stream. It partitions each output vector of `LENY` samples into non-overlapping windows of `POOL` samples, with stride `POOL`, and emits the signed maximum of each window on a registered valid/ready output. If `LENY` is not a multiple of `POOL`, the final short window of a vector is emitted on its own and never merges into the next vector.

## Interface
Parameters:
- `WIDTH`, 8: sample width, two's-complement signed.
- `POOL`, 2: window length and stride. Must be ≥ 1.
- `LOGPOOL`, 1: width of the window counter, equal to max(1, ceil(log2(POOL))).
- `LENY`, 5: samples per input vector. Equals `LENX`-`LENF`+1 of the upstream convolution. Must be ≥ 1.
- `LOGLENY`, 3: width of the vector counter, equal to max(1, ceil(log2(LENY))).

Ports:
- `clk`, input, 1: single clock. All state is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `s_data_in_y`, input, `WIDTH`: signed sample from the convolution stage.
- `s_valid_y`, input, 1: the upstream sample is valid.
- `s_ready_y`, output, 1: this block can accept a sample this cycle.
- `m_data_out_z`, output, `WIDTH`: signed pooled maximum.
- `m_valid_z`, output, 1: `m_data_out_z` is valid.
- `m_ready_z`, input, 1: downstream accepts the output.

## Operation
Internal state:
- `cnt`: position within the current window, 0..`POOL`-1.
- `fcnt`: position within the current vector, 0..`LENY`-1.
- `max_r`: running maximum of the current window.
- Output register: `m_data_out_z` plus `m_valid_z`. `m_valid_z` acts as the two-state output FSM: EMPTY (0) or FULL (1).

Reset values (asynchronous):
- `m_valid_z`=0, `m_data_out_z`=0, `cnt`=0, `fcnt`=0, `max_r`=0.

Handshake signals:
- `accept` = `s_valid_y` & `s_ready_y`.
- `closing` = (`cnt`==`POOL`-1) | (`fcnt`==`LENY`-1).
- `cand` = `s_data_in_y` when `cnt`==0, otherwise signed max(`max_r`, `s_data_in_y`).
- `s_ready_y` = !(`closing` & `m_valid_z` & !`m_ready_z`). This is combinational from `m_ready_z`. Non-closing samples are always accepted, even while the output is FULL.

On `accept` with `closing`=0:
- `max_r` ← `cand`.
- `cnt` ← `cnt`+1.
- `fcnt` ← `fcnt`+1.

On `accept` with `closing`=1:
- `m_data_out_z` ← `cand` and `m_valid_z` ← 1.
- `cnt` ← 0.
- `fcnt` ← 0 if `fcnt`==`LENY`-1, otherwise `fcnt`+1.

Output drain:
- When `m_valid_z` & `m_ready_z` and no closing accept occurs in the same cycle, `m_valid_z` ← 0.
- If a drain and a closing accept coincide, the new value loads and `m_valid_z` stays 1.
- While `m_valid_z`=1 & `m_ready_z`=0, `m_data_out_z` is held stable.

Arithmetic:
- Comparison is signed at `WIDTH` bits. There is no overflow or rounding.
- Ties keep either operand; the value is the same.

Boundary conditions:
- `POOL`=1: every sample is closing, so the block acts as a one-entry registered pipe.
- `POOL` ≥ `LENY`: one output per vector, the maximum of the whole vector.
- Partial window at the end of a vector: `cnt` resets to 0 together with `fcnt`, so no state carries into the next vector.
- Reset mid-window or mid-hold: the partial window and any unsent output are discarded. Processing restarts at the next vector boundary as seen by upstream; upstream is reset by the same signal.

## Timing
- Latency: a closing sample accepted at edge k makes `m_valid_z`=1 with the result right after edge k. There is one cycle of latency from `accept`.
- Throughput: one sample per cycle, sustained, whenever `m_ready_z`=1. There are no bubbles at window or vector boundaries.
- Backpressure: only a closing sample stalls, and only while the output is FULL and not being drained.
- Asynchronous reset forces `m_valid_z`=0 and `s_ready_y`=1 immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
Unless stated otherwise, `POOL`=2, `LENY`=5, `WIDTH`=8.

- **Continuous stream:** with `m_ready_z`=1, stream 3, −1, 7, 7, 2 back-to-back → outputs 3, 7, 2, each valid exactly one cycle after samples 2, 4 and 5; `s_ready_y` is never 0.
- **Negative samples:** stream −5, −3, −128, −127, −1 → outputs −3, −127, −1. This checks signed compare and extremes.
- **Backpressure:** hold `m_ready_z`=0 and send 1, 4, 9, 6 → 4 is registered and 9 is accepted. 6 sees `s_ready_y`=0 until `m_ready_z` rises, then is accepted in the same cycle. Outputs in order: 4, 9 (last partial window of 1 sample → 9? no: 9, 6 window → 9), then the fifth sample closes its own window.
- **Simultaneous drain and load:** keep `m_ready_z`=1 throughout an output hold with a closing sample arriving in the drain cycle → `m_valid_z` stays 1 with no gap, and the new value appears next cycle.
- **Asynchronous reset mid-window:** send 5, then pulse `reset` between clock edges → `m_valid_z` drops immediately. Then send 2, 1, 0, 0, 0 → first output is 2, not 5.
- **Frame boundary:** send two back-to-back vectors, 1 2 3 4 50 followed by 6 7 8 9 10 → six outputs: 2, 4, 50, 7, 9, 10. The 50 is not merged with 6.
